// File: rtl/regs_pkg.sv
// Shared types and sizes for the integer register file write-back path.
package regs_pkg;

    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    typedef struct packed {
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo2w.sv
// In-order write-back queue with two write ports (port 0 is older) and one read port.
// The entry array and valid bits are exported so the parent can build its pending mask.
module wb_fifo2w
    import regs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0_i,
    input  wb_req_t                    req0_i,
    input  logic                       push1_i,
    input  wb_req_t                    req1_i,
    input  logic                       pop_i,
    output wb_req_t                    head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DEPTH-1:0]           valid_o,
    output wb_req_t                    entries_o [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    wb_req_t          mem_q [DEPTH];

    logic             do_pop;
    logic             we_a, we_b;
    logic [PW-1:0]    slot_a, slot_b;
    wb_req_t          data_a, data_b;

    // Port A takes the oldest accepted request; port B is only used for a double push.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        we_a     = push0_i || push1_i;
        we_b     = push0_i && push1_i;
        slot_a   = wr_ptr_q;
        slot_b   = wr_ptr_q + PW'(1);
        data_a   = push0_i ? req0_i : req1_i;
        data_b   = req1_i;
        wr_ptr_d = wr_ptr_q + PW'(we_a) + PW'(we_b);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(we_a) + CW'(we_b) - CW'(do_pop);
        valid_d  = valid_q;
        if (do_pop) valid_d[rd_ptr_q] = 1'b0;
        if (we_a)   valid_d[slot_a]   = 1'b1;
        if (we_b)   valid_d[slot_b]   = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: storage is deliberately not reset; valid_q alone decides which entries mean anything.
    always_ff @(posedge clk) begin
        if (we_a) mem_q[slot_a] <= data_a;
        if (we_b) mem_q[slot_b] <= data_b;
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign valid_o   = valid_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/regs_wb_sched.sv
// Write-back scheduler: arbitrates LSU/EX write requests into an in-order queue and
// drains one write per cycle onto the register file port, exporting a pending mask.
module regs_wb_sched
    import regs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = regs_pkg::XLEN,
    parameter int AW    = regs_pkg::AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lsu_valid_i,
    output logic                   lsu_ready_o,
    input  logic [AW-1:0]          lsu_waddr_i,
    input  logic [XLEN-1:0]        lsu_wdata_i,
    input  logic                   ex_valid_i,
    output logic                   ex_ready_o,
    input  logic [AW-1:0]          ex_waddr_i,
    input  logic [XLEN-1:0]        ex_wdata_i,
    output logic                   reg_wen_o,
    output logic [AW-1:0]          reg_waddr_o,
    output logic [XLEN-1:0]        reg_wdata_o,
    output logic [31:0]            pending_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic [DEPTH-1:0] valid;
    wb_req_t          entries [DEPTH];
    wb_req_t          head;
    wb_req_t          req0, req1;
    logic             lsu_push, ex_push, pop;

    logic             reg_wen_q, reg_wen_d;
    logic [AW-1:0]    reg_waddr_q, reg_waddr_d;
    logic [XLEN-1:0]  reg_wdata_q, reg_wdata_d;

    // Readies look only at registered occupancy; EX yields a slot when the older LSU is also asking.
    always_comb begin
        free        = CW'(DEPTH) - count;
        lsu_ready_o = rst && (free >= CW'(1));
        ex_ready_o  = rst && (lsu_valid_i ? (free >= CW'(2)) : (free >= CW'(1)));
        lsu_push    = lsu_valid_i && lsu_ready_o && (lsu_waddr_i != '0);
        ex_push     = ex_valid_i && ex_ready_o && (ex_waddr_i != '0);
        req0        = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
        req1        = '{waddr: ex_waddr_i, wdata: ex_wdata_i};
        pop         = (count != '0);
    end

    wb_fifo2w #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0_i   (lsu_push),
        .req0_i    (req0),
        .push1_i   (ex_push),
        .req1_i    (req1),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (count),
        .valid_o   (valid),
        .entries_o (entries)
    );

    // Address/data hold their last value when idle so the port only toggles on real writes.
    always_comb begin
        reg_wen_d   = pop;
        reg_waddr_d = pop ? head.waddr : reg_waddr_q;
        reg_wdata_d = pop ? head.wdata : reg_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // NOTE: every variable in this block gets a default first, so no latch can be inferred.
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) pending_o[entries[i].waddr] = 1'b1;
        end
        pending_o[0] = 1'b0;
    end

    assign reg_wen_o   = reg_wen_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign count_o     = count;
    assign empty_o     = (count == '0);

endmodule

// File: tb/tb_regs_wb_sched.sv
// Self-checking bench for regs_wb_sched: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based reference model.
module tb_regs_wb_sched;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_waddr = '0;
    logic [XLEN-1:0] lsu_wdata = '0;
    logic            ex_valid = 1'b0;
    logic            ex_ready;
    logic [AW-1:0]   ex_waddr = '0;
    logic [XLEN-1:0] ex_wdata = '0;
    logic            reg_wen;
    logic [AW-1:0]   reg_waddr;
    logic [XLEN-1:0] reg_wdata;
    logic [31:0]     pending;
    logic [CW-1:0]   count;
    logic            empty;

    always #5 clk = ~clk;

    regs_wb_sched #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .lsu_valid_i (lsu_valid),
        .lsu_ready_o (lsu_ready),
        .lsu_waddr_i (lsu_waddr),
        .lsu_wdata_i (lsu_wdata),
        .ex_valid_i  (ex_valid),
        .ex_ready_o  (ex_ready),
        .ex_waddr_i  (ex_waddr),
        .ex_wdata_i  (ex_wdata),
        .reg_wen_o   (reg_wen),
        .reg_waddr_o (reg_waddr),
        .reg_wdata_o (reg_wdata),
        .pending_o   (pending),
        .count_o     (count),
        .empty_o     (empty)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a plain queue of outstanding writes plus the last emitted write.
    ent_t            mq[$];
    logic            m_wen   = 1'b0;
    logic [AW-1:0]   m_waddr = '0;
    logic [XLEN-1:0] m_wdata = '0;
    logic            acc_l, acc_e;
    logic            saw_full3 = 1'b0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) p |= (32'd1 << mq[i].a);
        return p & ~32'd1;
    endfunction

    // One clock: check readies for the current inputs, clock, update model, check outputs.
    task automatic run_cycle();
        int   free;
        logic exp_lr, exp_er;
        ent_t e;
        #1;
        free   = DEPTH - mq.size();
        exp_lr = rst && (free >= 1);
        exp_er = rst && (lsu_valid ? (free >= 2) : (free >= 1));
        if (mq.size() == 3 && lsu_valid && ex_valid) saw_full3 = 1'b1;
        check("lsu_ready", XLEN'(lsu_ready), XLEN'(exp_lr));
        check("ex_ready", XLEN'(ex_ready), XLEN'(exp_er));
        acc_l = lsu_valid && exp_lr;
        acc_e = ex_valid && exp_er;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            if (mq.size() > 0) begin
                e       = mq.pop_front();
                m_wen   = 1'b1;
                m_waddr = e.a;
                m_wdata = e.d;
            end else begin
                m_wen = 1'b0;
            end
            if (acc_l && lsu_waddr != '0) mq.push_back('{lsu_waddr, lsu_wdata});
            if (acc_e && ex_waddr != '0)  mq.push_back('{ex_waddr, ex_wdata});
        end
        #1;
        check("reg_wen", XLEN'(reg_wen), XLEN'(m_wen));
        check("reg_waddr", XLEN'(reg_waddr), XLEN'(m_waddr));
        check("reg_wdata", reg_wdata, m_wdata);
        check("pending", XLEN'(pending), XLEN'(model_pending()));
        check("count", XLEN'(count), XLEN'(mq.size()));
        check("empty", XLEN'(empty), XLEN'(mq.size() == 0));
    endtask

    task automatic set_req(input logic lv, input logic [AW-1:0] la, input logic [XLEN-1:0] ld,
                           input logic ev, input logic [AW-1:0] ea, input logic [XLEN-1:0] ed);
        lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
        ex_valid  = ev; ex_waddr  = ea; ex_wdata  = ed;
    endtask

    task automatic idle(input int n);
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int next_addr;
        int cnt_before;

        // Reset held two cycles with EX asking: readies stay low, outputs cleared.
        rst = 1'b0;
        set_req(1'b0, '0, '0, 1'b1, 5'd9, 64'h1234);
        run_cycle();
        run_cycle();
        check("rst_empty", XLEN'(empty), 1);
        check("rst_count", XLEN'(count), 0);
        check("rst_ex_ready", XLEN'(ex_ready), 0);
        rst = 1'b1;
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        check("ready_after_release", XLEN'(ex_ready), 1);
        idle(1);

        // Single EX write to x5.
        set_req(1'b0, '0, '0, 1'b1, 5'd5, 64'hDEAD_BEEF);
        run_cycle();
        check("x5_pending_set", XLEN'(pending[5]), 1);
        check("x5_no_wen_yet", XLEN'(reg_wen), 0);
        idle(1);
        check("x5_wen", XLEN'(reg_wen), 1);
        check("x5_waddr", XLEN'(reg_waddr), 5);
        check("x5_wdata", reg_wdata, 64'hDEAD_BEEF);
        check("x5_pending_clr", XLEN'(pending[5]), 0);
        idle(2);

        // Same-cycle LSU and EX to x7: LSU drains first, pending held until second pop.
        set_req(1'b1, 5'd7, 64'h11, 1'b1, 5'd7, 64'h22);
        run_cycle();
        check("x7_count2", XLEN'(count), 2);
        idle(1);
        check("x7_first", reg_wdata, 64'h11);
        check("x7_still_pending", XLEN'(pending[7]), 1);
        idle(1);
        check("x7_second", reg_wdata, 64'h22);
        check("x7_pending_clr", XLEN'(pending[7]), 0);
        idle(2);

        // Fill with both producers always valid and drain running; blocked requests hold.
        next_addr = 1;
        set_req(1'b1, 5'(next_addr), 64'(100 + next_addr), 1'b1, 5'(next_addr + 1), 64'(101 + next_addr));
        next_addr += 2;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (acc_l) begin
                lsu_waddr = 5'(next_addr % 31 + 1);
                lsu_wdata = 64'(1000 + next_addr);
                next_addr++;
            end
            if (acc_e) begin
                ex_waddr = 5'(next_addr % 31 + 1);
                ex_wdata = 64'(1000 + next_addr);
                next_addr++;
            end
        end
        check("fill_reached_3", XLEN'(saw_full3), 1);
        idle(5);

        // Write to x0 is consumed without a slot or a register-file write.
        cnt_before = int'(count);
        set_req(1'b0, '0, '0, 1'b1, 5'd0, 64'hFF);
        run_cycle();
        check("x0_count", XLEN'(count), XLEN'(cnt_before));
        check("x0_pending", XLEN'(pending), 0);
        idle(1);
        check("x0_no_wen", XLEN'(reg_wen), 0);

        // Reset with three queued entries: nothing queued ever reaches the register file.
        set_req(1'b1, 5'd10, 64'hA0, 1'b1, 5'd11, 64'hA1);
        run_cycle();
        set_req(1'b1, 5'd12, 64'hA2, 1'b1, 5'd13, 64'hA3);
        run_cycle();
        check("pre_rst_count3", XLEN'(count), 3);
        rst = 1'b0;
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        run_cycle();
        check("mid_rst_count", XLEN'(count), 0);
        check("mid_rst_wen", XLEN'(reg_wen), 0);
        check("mid_rst_pending", XLEN'(pending), 0);
        rst = 1'b1;
        idle(4);

        // Randomized traffic: a request that is not accepted keeps its address and data.
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            run_cycle();
            if (acc_l || !lsu_valid) begin
                lsu_valid = ($urandom_range(0, 3) != 0);
                lsu_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                lsu_wdata = {$urandom, $urandom};
            end
            if (acc_e || !ex_valid) begin
                ex_valid = ($urandom_range(0, 2) != 0);
                ex_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ex_wdata = {$urandom, $urandom};
            end
        end
        rst = 1'b1;
        idle(6);
        check("final_empty", XLEN'(empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
- Write-back scheduler in front of the 32x64 integer register file's single write port.
- Accepts write requests from two producers, the load/store unit (LSU, older instruction) and the ALU (EX, younger), through valid/ready handshakes.
- Buffers requests in an in-order queue and drains them onto the register file write port at one per cycle.
- Exports a per-register pending mask so ID can stall on registers whose write-back has not yet reached the register file.

Parameters:
- DEPTH, 4, queue entries; power of 2, >= 2
- XLEN, 64, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- lsu_valid_i  in  1  LSU write request valid
- lsu_ready_o  out  1  LSU request accepted this cycle when valid & ready
- lsu_waddr_i  in  AW  LSU destination register
- lsu_wdata_i  in  XLEN  LSU write data
- ex_valid_i  in  1  EX write request valid
- ex_ready_o  out  1  EX request accepted this cycle when valid & ready
- ex_waddr_i  in  AW  EX destination register
- ex_wdata_i  in  XLEN  EX write data
- reg_wen_o  out  1  register file write enable
- reg_waddr_o  out  AW  register file write address
- reg_wdata_o  out  XLEN  register file write data
- pending_o  out  32  bit r set while a write to xr sits in the queue
- count_o  out  log2(DEPTH)+1  queue occupancy
- empty_o  out  1  count_o == 0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-low.
- Reset (rst==0 at a posedge): count 0, rd/wr pointers 0, reg_wen_o 0, reg_waddr_o 0, reg_wdata_o 0, pending_o 0, empty_o 1.
  - Reset mid-operation discards all queued writes; nothing reaches the register file.
- Ready rules are combinational and use registered occupancy only; there is no credit for a same-cycle dequeue. With free = DEPTH - count:
  - lsu_ready_o = (free >= 1).
  - ex_ready_o = (free >= 2) if lsu_valid_i, else (free >= 1).
  - Both readies are 0 while rst==0.
- Enqueue:
  - An accepted request with waddr != 0 is written to the queue.
  - Same-cycle double accept: the LSU entry goes first (older), then EX, occupying two slots.
  - Accepted requests with waddr == 0 are consumed and dropped: no slot, no pending bit.
  - Pointers wrap modulo DEPTH.
- Dequeue:
  - Each cycle with count > 0 (registered), the head is popped.
  - At the next posedge the head drives reg_wen_o=1, reg_waddr_o and reg_wdata_o.
  - Otherwise reg_wen_o=0 and the address/data outputs hold their last values.
  - Latency: request accepted at edge N, with the queue empty before N, gives reg_wen_o high after edge N+1. The register file commits at edge N+2.
  - Throughput is 1 write per cycle; drain order equals accept order.
- Simultaneous enqueue and dequeue in one cycle is legal; count' = count + accepted_nonzero - pop.
- Full: count==DEPTH gives both readies 0 and no state corruption. A valid held high under backpressure must keep its addr/data stable; the bench checks this.
- Empty: no pop and reg_wen_o=0.
- pending_o: combinational OR over occupied entries of onehot(waddr).
  - A register stays pending while any queued entry targets it, including duplicates.
  - It clears in the cycle its last entry is popped, i.e. when reg_wen_o goes high. The register file's internal write bypass covers that cycle.
  - Bit 0 is always 0.
- count_o and empty_o are registered state.

Decomposition:
- Shared package regs_pkg: XLEN, AW, NREGS=32, and a wb_req_t struct {waddr, wdata}.
- One sub-module, wb_fifo2w: a DEPTH-entry FIFO with 2 write ports and 1 read port.
  - Exposes its entry array and valid bits for the pending-mask logic.
- regs_wb_sched holds the ready logic, x0 filtering, output register and pending_o.

Test Plan:
- Reset with rst=0 for 2 cycles while ex_valid_i=1 -> all outputs 0, empty_o=1, ex_ready_o=0; after release, ready rises the same cycle.
- EX-only write x5=0xDEAD_BEEF, queue empty -> reg_wen_o=1, waddr 5, data 0xDEADBEEF exactly one cycle after accept; pending_o[5]=1 for one cycle, then 0.
- Same-cycle LSU x7=0x11 and EX x7=0x22 -> writes emitted on consecutive cycles in order 0x11 then 0x22; pending_o[7] stays high until the second pop.
- Fill to DEPTH=4 with both valid every cycle and the drain running -> readies drop correctly. At count=3 with both valid: lsu_ready_o=1, ex_ready_o=0. All accepted writes appear exactly once, in order.
- Write to x0 from EX (data 0xFF) -> accepted, reg_wen_o never asserts, count_o unchanged, pending_o==0.
- rst pulsed low with 3 entries queued -> next cycles reg_wen_o=0, count_o=0, pending_o=0, and no queued data is ever written.
